noc_mmio_bridge: RTL
====================

Name: noc_mmio_bridge

Overview:
- Parametrised memory-mapped IO bridge between the picorv32 native memory bus and one NoC node's message ports.
- Replaces the fixed, unbuffered IO case-decode with a decoded register window.
- Adds buffered TX/RX FIFOs, per-word destination tagging, status/count registers and sticky error flags.
- Sits beside on-chip RAM in the system wrapper; the wrapper muxes mem_rdata/mem_ready using io_sel.

Parameters:
- IO_BASE, 32'h1000_0000: base byte address of the 64-byte register window.
- COORD_BITS, 1: width of X and Y coordinates.
- X_COORD, 0: this node's X coordinate.
- Y_COORD, 0: this node's Y coordinate.
- NODE_NUMBER, 0: this node's index.
- MSG_WIDTH, 32: message payload width, 1..32.
- TX_DEPTH, 4: TX FIFO entries, power of 2, 2..128.
- RX_DEPTH, 4: RX FIFO entries, power of 2, 2..128.
- LED_WIDTH, 4: LED register width, 1..32.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  picorv32 request valid
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 means read
- io_sel  out  1  combinational: mem_valid AND address inside the window
- mem_ready  out  1  bridge response ready
- mem_rdata  out  32  bridge read data
- switch  in  1  board switch
- led  out  LED_WIDTH  LED register
- out_byte  out  8  character output
- out_byte_en  out  1  character strobe
- tx_x  out  COORD_BITS  head-word destination X
- tx_y  out  COORD_BITS  head-word destination Y
- tx_data  out  MSG_WIDTH  head-word payload
- tx_last  out  1  head word ends its packet
- tx_valid  out  1  TX head valid
- tx_ready  in  1  NoC accepts TX head
- rx_data  in  MSG_WIDTH  incoming payload
- rx_valid  in  1  incoming word valid
- rx_ready  out  1  RX FIFO not full

Behaviour:
- Reset: asynchronous assert of reset forces every output register to 0 (mem_ready, mem_rdata, led, out_byte, out_byte_en, tx_valid, dest, error flags) and empties both FIFOs.
- Reset mid-transaction: the pending access is dropped and no mem_ready is issued. rx_ready=0 while reset is high.
- Bus handshake: when io_sel=1 and mem_ready=0, the bridge registers the access and asserts mem_ready for exactly one cycle on the next edge. mem_rdata is valid in that same cycle.
  - Write side effects take place at that accepting edge.
  - mem_ready is never asserted for out-of-window addresses.
- Register map (byte offsets). Reads of W-only or unmapped offsets return 0; writes to RO or unmapped offsets are ignored.
  - 0x00 CHAR (W): out_byte <= wdata[7:0]; out_byte_en pulses for 1 cycle.
  - 0x04 LED (RW): led <= wdata[LED_WIDTH-1:0].
  - 0x08 SWITCH (R): {31'b0, switch}.
  - 0x0C DEST (RW): x = wdata[COORD_BITS-1:0], y = wdata[16+COORD_BITS-1:16]. Held until rewritten.
  - 0x10 TX_DATA (W): push {last=0, dest, wdata[MSG_WIDTH-1:0]}.
  - 0x14 TX_LAST (W): push {last=1, dest, wdata}.
  - 0x18 RX_DATA (R): pop the RX head and return it zero-extended.
  - 0x1C STATUS (R):
    - bit0 tx_full, bit1 tx_empty, bit2 rx_avail, bit3 rx_full.
    - [15:8] tx_count, [23:16] rx_count, each sized log2(DEPTH)+1 bits and zero-padded.
  - 0x20 NODE (R): [7:0] NODE_NUMBER, [15:8] X_COORD, [23:16] Y_COORD.
  - 0x24 ERR (R; W1C): bit0 tx_overflow, bit1 rx_underflow, bit2 rx_overrun.
- TX FIFO:
  - tx_* show the head word first-word-fall-through; tx_valid = !tx_empty.
  - A word is popped when tx_valid && tx_ready.
  - A CPU push while full is dropped and sets tx_overflow.
  - Push and pop in the same cycle while full: the pop frees the slot, so the push succeeds and the count is unchanged.
- RX FIFO:
  - rx_ready = !rx_full. A word is pushed when rx_valid && rx_ready.
  - rx_valid while full is not accepted and sets rx_overrun (upstream must hold the word).
  - Reading RX_DATA while empty returns 0 and sets rx_underflow.
  - Simultaneous CPU pop and NoC push: both occur; when empty, the CPU read underflows and the pushed word is kept.
- Counts: the pointer bits wrap modulo DEPTH, with an extra MSB to tell full from empty.
- ERR: write-1-to-clear. If a set event and a clear occur in the same cycle, the set wins.
- Status latency: STATUS reflects FIFO state at the accepting edge (before that cycle's updates).

Decomposition:
- Package noc_mmio_pkg holds:
  - the register offset constants (CHAR_OFS … ERR_OFS);
  - STATUS and ERR bit-index constants;
  - the window size (64).
- Sub-module sync_fifo, parameters WIDTH and DEPTH, instantiated twice:
  - valid/ready push and pop;
  - FWFT head, count, full, empty.

Test Plan:
- Reset release, then read STATUS → 0x0000_0002 (tx_empty only). Read NODE with NODE_NUMBER=3, X=1, Y=0 → 0x0000_0103.
- DEST=0x0001_0000, write TX_DATA 0xA5 then TX_LAST 0x5A with tx_ready=0 → tx_count=2. Then tx_ready=1 → tx words {y=1, x=0, 0xA5, last=0} then {…, 0x5A, last=1} on consecutive cycles, then tx_valid=0.
- Write TX_DEPTH+1 words with tx_ready=0 → final STATUS shows tx_full with tx_count=TX_DEPTH; ERR=0x1. Write ERR=0x1 → ERR reads 0.
- Drive 4 RX words 0x11..0x14 (RX_DEPTH=4) plus a 5th held valid → rx_ready=0 and ERR bit2 set. Four RX_DATA reads return 0x11..0x14; the 5th word is accepted after the first pop and the 5th read returns it.
- RX_DATA read while empty → 0 and ERR=0x2. Write CHAR 0x41 → out_byte=0x41 with a 1-cycle out_byte_en. LED write 0xF → led=4'hF.
- Assert reset while a TX word is pending and during an accepted access → tx_valid=0, no mem_ready pulse, STATUS=0x2 after release.

Source files
------------

// File: rtl/noc_mmio_pkg.sv
// noc_mmio_pkg: shared constants for the NoC MMIO bridge.
//   - register byte offsets inside the 64-byte window
//   - STATUS and ERR bit positions
//   - window size
package noc_mmio_pkg;

   localparam int WINDOW_BYTES = 64;

   localparam logic [5:0] CHAR_OFS    = 6'h00;
   localparam logic [5:0] LED_OFS     = 6'h04;
   localparam logic [5:0] SWITCH_OFS  = 6'h08;
   localparam logic [5:0] DEST_OFS    = 6'h0C;
   localparam logic [5:0] TX_DATA_OFS = 6'h10;
   localparam logic [5:0] TX_LAST_OFS = 6'h14;
   localparam logic [5:0] RX_DATA_OFS = 6'h18;
   localparam logic [5:0] STATUS_OFS  = 6'h1C;
   localparam logic [5:0] NODE_OFS    = 6'h20;
   localparam logic [5:0] ERR_OFS     = 6'h24;

   // STATUS bit positions
   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_AVAIL = 2;
   localparam int ST_RX_FULL  = 3;

   // ERR bit positions (sticky, write-1-to-clear)
   localparam int ERR_TX_OVERFLOW  = 0;
   localparam int ERR_RX_UNDERFLOW = 1;
   localparam int ERR_RX_OVERRUN   = 2;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through head.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   push_valid_i/_ready_o/_data_i   write side (valid/ready)
//   pop_valid_o/_ready_i/_data_o    read side, pop_data_o shows the head
//   count_o, full_o, empty_o        occupancy
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A push into a full FIFO is accepted when a pop frees the slot in
// the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_valid_i,
   output logic                     push_ready_o,
   input  logic [WIDTH-1:0]         push_data_i,
   output logic                     pop_valid_o,
   input  logic                     pop_ready_i,
   output logic [WIDTH-1:0]         pop_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             push_fire;
   logic             pop_fire;

   // Pointers carry one extra MSB so full and empty are distinguishable;
   // with DEPTH a power of two the count MSB is set only when full.
   assign count_o      = wr_q - rd_q;
   assign empty_o      = (wr_q == rd_q);
   assign full_o       = count_o[AW];
   assign pop_valid_o  = !empty_o;
   assign pop_fire     = pop_ready_i && !empty_o;
   assign push_ready_o = !full_o || pop_fire;
   assign push_fire    = push_valid_i && push_ready_o;
   assign pop_data_o   = mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_fire) wr_d = wr_q + (AW+1)'(1);
      if (pop_fire)  rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage is not reset; only the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (push_fire) mem_q[wr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/noc_mmio_bridge.sv
// noc_mmio_bridge: picorv32 native-bus register window onto one NoC node.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   mem_valid/addr/wdata/wstrb      CPU request (wstrb==0 is a read)
//   io_sel                          request targets this window (combinational)
//   mem_ready/mem_rdata             one-cycle response, data valid with ready
//   switch, led                     board IO
//   out_byte, out_byte_en           character output with one-cycle strobe
//   tx_x/tx_y/tx_data/tx_last       TX FIFO head, valid/ready with tx_valid/tx_ready
//   rx_data/rx_valid/rx_ready       RX FIFO input, valid/ready
// An access is accepted on the edge where io_sel is high and mem_ready is low;
// mem_ready then stays high for exactly that following cycle. Any nonzero
// strobe is treated as a full-word write.
module noc_mmio_bridge
   import noc_mmio_pkg::*;
#(
   parameter logic [31:0] IO_BASE     = 32'h1000_0000,
   parameter int          COORD_BITS  = 1,
   parameter int          X_COORD     = 0,
   parameter int          Y_COORD     = 0,
   parameter int          NODE_NUMBER = 0,
   parameter int          MSG_WIDTH   = 32,
   parameter int          TX_DEPTH    = 4,
   parameter int          RX_DEPTH    = 4,
   parameter int          LED_WIDTH   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_valid,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_wdata,
   input  logic [3:0]            mem_wstrb,
   output logic                  io_sel,
   output logic                  mem_ready,
   output logic [31:0]           mem_rdata,
   input  logic                  switch,
   output logic [LED_WIDTH-1:0]  led,
   output logic [7:0]            out_byte,
   output logic                  out_byte_en,
   output logic [COORD_BITS-1:0] tx_x,
   output logic [COORD_BITS-1:0] tx_y,
   output logic [MSG_WIDTH-1:0]  tx_data,
   output logic                  tx_last,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [MSG_WIDTH-1:0]  rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready
);

   localparam int TXW = 1 + 2*COORD_BITS + MSG_WIDTH;

   logic [31:0]           offset;
   logic [5:0]            ofs;
   logic                  accept, is_wr, wr_acc, rd_acc;
   logic                  mem_ready_q;
   logic [31:0]           mem_rdata_q, rdata_d;
   logic [LED_WIDTH-1:0]  led_q;
   logic [7:0]            out_byte_q;
   logic                  out_byte_en_q;
   logic [COORD_BITS-1:0] dest_x_q, dest_y_q;
   logic [2:0]            err_q, err_d;

   logic                  tx_push, tx_push_ready, tx_full, tx_empty, tx_pop;
   logic [TXW-1:0]        tx_head;
   logic [$clog2(TX_DEPTH):0] tx_count;
   logic                  rx_pop, rx_full, rx_empty, rx_avail;
   logic [MSG_WIDTH-1:0]  rx_head;
   logic [$clog2(RX_DEPTH):0] rx_count;
   logic                  tx_overflow, rx_underflow, rx_overrun;
   logic                  unused_bits;

   // Subtracting the base keeps the window test correct for any IO_BASE.
   assign offset = mem_addr - IO_BASE;
   assign ofs    = {offset[5:2], 2'b00};
   assign io_sel = mem_valid && (offset < 32'(WINDOW_BYTES));
   assign accept = io_sel && !mem_ready_q;
   assign is_wr  = (mem_wstrb != 4'b0000);
   assign wr_acc = accept && is_wr;
   assign rd_acc = accept && !is_wr;

   assign unused_bits = ^{mem_wdata, offset[1:0]};

   // TX: CPU pushes {last, y, x, payload}; NoC drains the FWFT head.
   assign tx_push     = wr_acc && (ofs == TX_DATA_OFS || ofs == TX_LAST_OFS);
   assign tx_pop      = tx_valid && tx_ready;
   assign tx_overflow = tx_push && !tx_push_ready;

   sync_fifo #(.WIDTH(TXW), .DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk_i        (clk),
      .rst_i        (reset),
      .push_valid_i (tx_push),
      .push_ready_o (tx_push_ready),
      .push_data_i  ({(ofs == TX_LAST_OFS), dest_y_q, dest_x_q, mem_wdata[MSG_WIDTH-1:0]}),
      .pop_valid_o  (tx_valid),
      .pop_ready_i  (tx_ready),
      .pop_data_o   (tx_head),
      .count_o      (tx_count),
      .full_o       (tx_full),
      .empty_o      (tx_empty)
   );

   assign tx_data = tx_head[MSG_WIDTH-1:0];
   assign tx_x    = tx_head[MSG_WIDTH +: COORD_BITS];
   assign tx_y    = tx_head[MSG_WIDTH+COORD_BITS +: COORD_BITS];
   assign tx_last = tx_head[TXW-1];

   // RX: rx_ready is forced low during reset so nothing is taken then.
   assign rx_ready     = !rx_full && !reset;
   assign rx_pop       = rd_acc && (ofs == RX_DATA_OFS);
   assign rx_underflow = rx_pop && rx_empty;
   assign rx_overrun   = rx_valid && rx_full;

   sync_fifo #(.WIDTH(MSG_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk_i        (clk),
      .rst_i        (reset),
      .push_valid_i (rx_valid && rx_ready),
      .push_ready_o (),
      .push_data_i  (rx_data),
      .pop_valid_o  (rx_avail),
      .pop_ready_i  (rx_pop),
      .pop_data_o   (rx_head),
      .count_o      (rx_count),
      .full_o       (rx_full),
      .empty_o      (rx_empty)
   );

   // Read data reflects state before this edge's FIFO/register updates.
   always_comb begin
      rdata_d = '0;
      if (!is_wr) begin
         case (ofs)
            LED_OFS:     rdata_d = 32'(led_q);
            SWITCH_OFS:  rdata_d = {31'b0, switch};
            DEST_OFS:    rdata_d = (32'(dest_y_q) << 16) | 32'(dest_x_q);
            RX_DATA_OFS: rdata_d = rx_empty ? 32'b0 : 32'(rx_head);
            STATUS_OFS: begin
               rdata_d[ST_TX_FULL]  = tx_full;
               rdata_d[ST_TX_EMPTY] = tx_empty;
               rdata_d[ST_RX_AVAIL] = rx_avail;
               rdata_d[ST_RX_FULL]  = rx_full;
               rdata_d[15:8]        = 8'(tx_count);
               rdata_d[23:16]       = 8'(rx_count);
            end
            NODE_OFS:    rdata_d = {8'b0, 8'(Y_COORD), 8'(X_COORD), 8'(NODE_NUMBER)};
            ERR_OFS:     rdata_d = {29'b0, err_q};
            default:     rdata_d = '0;
         endcase
      end
   end

   // Clear first so a simultaneous set event wins.
   always_comb begin
      err_d = err_q;
      if (wr_acc && ofs == ERR_OFS) err_d = err_q & ~mem_wdata[2:0];
      if (tx_overflow)  err_d[ERR_TX_OVERFLOW]  = 1'b1;
      if (rx_underflow) err_d[ERR_RX_UNDERFLOW] = 1'b1;
      if (rx_overrun)   err_d[ERR_RX_OVERRUN]   = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_ready_q   <= 1'b0;
         mem_rdata_q   <= '0;
         led_q         <= '0;
         out_byte_q    <= '0;
         out_byte_en_q <= 1'b0;
         dest_x_q      <= '0;
         dest_y_q      <= '0;
         err_q         <= '0;
      end else begin
         mem_ready_q   <= accept;
         out_byte_en_q <= 1'b0;
         err_q         <= err_d;
         if (accept) mem_rdata_q <= rdata_d;
         if (wr_acc) begin
            case (ofs)
               CHAR_OFS: begin
                  out_byte_q    <= mem_wdata[7:0];
                  out_byte_en_q <= 1'b1;
               end
               LED_OFS:  led_q <= mem_wdata[LED_WIDTH-1:0];
               DEST_OFS: begin
                  dest_x_q <= mem_wdata[COORD_BITS-1:0];
                  dest_y_q <= mem_wdata[16 +: COORD_BITS];
               end
               default: ;
            endcase
         end
      end
   end

   assign mem_ready   = mem_ready_q;
   assign mem_rdata   = mem_rdata_q;
   assign led         = led_q;
   assign out_byte    = out_byte_q;
   assign out_byte_en = out_byte_en_q;

endmodule
